bsg_credit_batcher: RTL and testbench
=====================================

BSG_CREDIT_BATCHER -- requirements
Module: bsg_credit_batcher

Interface
- REQ-001: Parameter max_step_p, default 4, is the maximum credits accepted or released per cycle.
- REQ-002: Parameter batch_p, default 4, is the pending count that triggers an immediate drain; legal range 1..max_step_p*2.
- REQ-003: Parameter timeout_p, default 8, is the cycles a partial batch waits before a forced drain; must be 2 or more.
- REQ-004: Parameter pending_max_p, default 63, is the capacity of the pending counter.
- REQ-005: clk_i  input  1  is the single clock; all state updates on its rising edge.
- REQ-006: reset_n_i  input  1  is the reset; it is asynchronous and active-low.
- REQ-007: credits_i  input  clog2(max_step_p+1) (3)  carries credits returned this cycle, range 0..max_step_p.
- REQ-008: credits_ready_o  output  1  indicates credits_i is accepted this cycle.
- REQ-009: flush_i  input  1  requests an immediate drain of all pending credits.
- REQ-010: hold_i  input  1  pauses release; while high, up_o is 0.
- REQ-011: up_o  output  clog2(max_step_p+1) (3)  carries credits released this cycle and drives the downstream up/down counter up input directly.

Function
- REQ-012: Registered state SHALL be pending_r (clog2(pending_max_p+1) bits), timer_r (clog2(timeout_p) bits) and state_r in {IDLE, ACCUM, DRAIN}.
- REQ-013: accepted SHALL equal credits_i when credits_ready_o=1, and 0 otherwise.
- REQ-014: credits_ready_o SHALL be 1 iff pending_r <= pending_max_p - max_step_p; it depends only on registers.
- REQ-015: up_o SHALL equal min(pending_r, max_step_p) when state_r=DRAIN and hold_i=0, and 0 otherwise.
- REQ-016: pending_next SHALL equal pending_r - up_o + accepted and SHALL never overflow or underflow.
- REQ-017: In IDLE with accepted=0, the block SHALL stay in IDLE; flush_i has no effect.
- REQ-018: In IDLE with accepted>0, the block SHALL go to DRAIN if flush_i=1 or pending_next>=batch_p; otherwise it SHALL go to ACCUM with timer_r cleared to 0.
- REQ-019: In ACCUM, timer_r SHALL increment by 1 each cycle.
- REQ-020: In ACCUM, the block SHALL go to DRAIN if pending_next>=batch_p, or flush_i=1, or timer_r=timeout_p-1.
- REQ-021: In DRAIN, the block SHALL go to IDLE when pending_next=0; otherwise it SHALL stay in DRAIN, including while new credits arrive.
- REQ-022: hold_i=1 in DRAIN SHALL freeze release; state remains DRAIN and accepted credits still accumulate.
- REQ-023: When flush_i and hold_i are both 1, hold_i SHALL win for release, and the state SHALL still move to DRAIN.
- REQ-024: Conservation: the cumulative sum of up_o SHALL equal the cumulative sum of accepted once the block has returned to IDLE.
- REQ-025: credits_i > max_step_p while credits_ready_o=1 is illegal; the block SHALL flag it with a simulation-only assertion, and its behaviour is undefined.

Reset
- REQ-026: While reset_n_i=0, the block SHALL asynchronously force pending_r=0, timer_r=0 and state_r=IDLE.
- REQ-027: As a result, up_o=0 and credits_ready_o=1 immediately, with no clock edge required.
- REQ-028: Reset asserted mid-DRAIN SHALL discard all pending credits; no partial release follows.
- REQ-029: Reset deassertion SHALL take effect at the first rising clk_i edge after reset_n_i rises.

Verification (defaults: batch_p=4, timeout_p=8, pending_max_p=63)
- REQ-030: Timeout: credits_i=1 for one cycle (cycle 0), then 0 -> up_o=1 in exactly cycle 9 only; state returns to IDLE at cycle 10.
- REQ-031: Full batch: credits_i=4 in cycle 0 -> up_o=4 in cycle 1 and 0 in cycle 2; state is IDLE at cycle 2.
- REQ-032: Split drain with flush: credits_i=3, 3, 3 in cycles 0-2, flush_i=1 in cycle 2 -> up_o=4, 4, 1 across the drain; total released equals 9.
- REQ-033: Backpressure: hold_i=1 with credits_i=4 every cycle -> pending_r climbs 4, 8, ..., 60; credits_ready_o=0 at pending_r=60; pending_r holds at 60.
- REQ-034: Release after backpressure: from the REQ-033 end state, drop hold_i and set credits_i=0 -> up_o=4 for 15 cycles, then IDLE.
- REQ-035: Reset mid-operation: pull reset_n_i low during DRAIN with pending_r=10 -> up_o=0 and credits_ready_o=1 before the next clk_i edge; after release, no residual up_o pulses.
- REQ-036: Random test: constrained-random credits_i, flush_i and hold_i with the scoreboard checking REQ-024 against a reference up/down counter, and checking that up_o never exceeds 4.

Source files
------------

// File: rtl/bsg_credit_batcher_if.sv
// Credit return / release bundle between a credit source and bsg_credit_batcher.
// Signal names keep the original port names so existing hookups map one-to-one.
interface bsg_credit_batcher_if #(
    parameter int unsigned step_w = 3
);
    logic [step_w-1:0] credits_i;
    logic              credits_ready_o;
    logic              flush_i;
    logic              hold_i;
    logic [step_w-1:0] up_o;

    modport master (
        output credits_i, flush_i, hold_i,
        input  credits_ready_o, up_o
    );

    modport slave (
        input  credits_i, flush_i, hold_i,
        output credits_ready_o, up_o
    );
endinterface

// File: rtl/bsg_credit_batcher.sv
// Collects returned credits and releases them downstream in batches of up to
// max_step_p per cycle, draining on a full batch, an explicit flush, or a timeout.
module bsg_credit_batcher #(
    parameter int unsigned max_step_p    = 4,
    parameter int unsigned batch_p       = 4,
    parameter int unsigned timeout_p     = 8,
    parameter int unsigned pending_max_p = 63
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bsg_credit_batcher_if.slave  bus
);
    localparam int unsigned step_w  = $clog2(max_step_p + 1);
    localparam int unsigned pend_w  = $clog2(pending_max_p + 1);
    localparam int unsigned timer_w = $clog2(timeout_p);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [pend_w-1:0]   pending_q, pending_d;
    logic [timer_w-1:0]  timer_q, timer_d;
    logic                credits_ready;
    logic [step_w-1:0]   accepted;
    logic [step_w-1:0]   up;
    logic                batch_full;

    // Ready looks only at registered state so it never depends on this cycle's inputs.
    assign credits_ready       = (pending_q <= pend_w'(pending_max_p - max_step_p));
    assign bus.credits_ready_o = credits_ready;
    assign bus.up_o            = up;

    always_comb begin
        accepted   = credits_ready ? bus.credits_i : '0;
        up         = '0;
        if (state_q == DRAIN && !bus.hold_i) begin
            up = (pending_q < pend_w'(max_step_p)) ? step_w'(pending_q) : step_w'(max_step_p);
        end
        pending_d  = pending_q - pend_w'(up) + pend_w'(accepted);
        batch_full = (pending_d >= pend_w'(batch_p));
        timer_d    = timer_q;
        state_d    = state_q;

        unique case (state_q)
            IDLE: begin
                if (accepted != '0) begin
                    if (bus.flush_i || batch_full) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ACCUM;
                        timer_d = '0;
                    end
                end
            end
            ACCUM: begin
                timer_d = timer_q + timer_w'(1);
                if (batch_full || bus.flush_i || timer_q == timer_w'(timeout_p - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pending_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(credits_ready && (bus.credits_i > step_w'(max_step_p))));
`endif

endmodule

// File: tb/tb_bsg_credit_batcher.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// credit-conservation scoreboard against a reference up/down counter.
module tb_bsg_credit_batcher;
    logic clk;
    logic rst_n;

    bsg_credit_batcher_if #(.step_w(3)) bus ();

    bsg_credit_batcher #(
        .max_step_p   (4),
        .batch_p      (4),
        .timeout_p    (8),
        .pending_max_p(63)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [2:0] credits;
        logic       flush;
        logic       hold;
        int         exp_up;
        int         exp_ready;
    } vec_t;

    vec_t vecs[$];
    int   sb_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   ref_cnt  = 0;
    int   last_up  = 0;
    int   cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        total++;
        if (act > lim) begin
            bad++;
            $display("FAIL %s: got %0d expected <= %0d (t=%0t)", name, act, lim, $time);
        end
    endtask

    task automatic add_vec(input logic [2:0] c, input logic f, input logic h,
                           input int up, input int rdy);
        vec_t v;
        v.credits = c; v.flush = f; v.hold = h; v.exp_up = up; v.exp_ready = rdy;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive after the edge, sample once settled, update scoreboard.
    task automatic step(input logic [2:0] c, input logic f, input logic h);
        int acc;
        int up;
        @(posedge clk);
        #1;
        bus.credits_i = c;
        bus.flush_i   = f;
        bus.hold_i    = h;
        #1;
        up  = int'(bus.up_o);
        acc = bus.credits_ready_o ? int'(c) : 0;
        check("ready_vs_ref", int'(bus.credits_ready_o), (ref_cnt <= 59) ? 1 : 0);
        check_le("up_bound", up, (ref_cnt < 4) ? ref_cnt : 4);
        if (up > 0) begin
            check_le("sb_release_vs_accepted", up, sb_q.size());
            for (int i = 0; i < up; i++) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
        end
        for (int i = 0; i < acc; i++) sb_q.push_back(cyc);
        ref_cnt = ref_cnt + acc - up;
        if (ref_cnt < 0) ref_cnt = 0;
        last_up = up;
        cyc++;
    endtask

    initial begin
        bus.credits_i = '0;
        bus.flush_i   = 1'b0;
        bus.hold_i    = 1'b0;
        rst_n         = 1'b1;

        // Timeout: single credit released in cycle 9 only
        add_vec(3'd1, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) add_vec(3'd0, 0, 0, 0, 1);
        add_vec(3'd0, 0, 0, 1, 1);
        add_vec(3'd0, 0, 0, 0, 1);
        // Full batch
        add_vec(3'd4, 0, 0, 0, 1);
        add_vec(3'd0, 0, 0, 4, 1);
        add_vec(3'd0, 0, 0, 0, 1);
        // Split drain with flush: 4, 4, 1
        add_vec(3'd3, 0, 0, 0, 1);
        add_vec(3'd3, 0, 0, 0, 1);
        add_vec(3'd3, 1, 0, 4, 1);
        add_vec(3'd0, 0, 0, 4, 1);
        add_vec(3'd0, 0, 0, 1, 1);
        add_vec(3'd0, 0, 0, 0, 1);
        // Flush with nothing accepted is ignored
        add_vec(3'd0, 1, 0, 0, 1);
        add_vec(3'd0, 0, 0, 0, 1);
        // Flush and hold together: hold gates release, state still drains
        add_vec(3'd2, 1, 1, 0, 1);
        add_vec(3'd0, 0, 1, 0, 1);
        add_vec(3'd0, 0, 0, 2, 1);
        add_vec(3'd0, 0, 0, 0, 1);
        // New credits arriving during drain keep it in DRAIN
        add_vec(3'd4, 0, 0, 0, 1);
        add_vec(3'd4, 0, 0, 4, 1);
        add_vec(3'd0, 0, 0, 4, 1);
        add_vec(3'd0, 0, 0, 0, 1);

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("reset_up", int'(bus.up_o), 0);
        check("reset_ready", int'(bus.credits_ready_o), 1);
        check("reset_pending", int'(dut.pending_q), 0);
        check("reset_state", int'(dut.state_q), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].credits, vecs[i].flush, vecs[i].hold);
            check($sformatf("vec%0d_up", i), last_up, vecs[i].exp_up);
            check($sformatf("vec%0d_ready", i), int'(bus.credits_ready_o), vecs[i].exp_ready);
        end

        // Full batch returns to IDLE at cycle 2
        step(3'd4, 0, 0);
        step(3'd0, 0, 0);
        check("batch_up_c1", last_up, 4);
        step(3'd0, 0, 0);
        check("batch_up_c2", last_up, 0);
        check("batch_state_c2", int'(dut.state_q), 0);

        // Backpressure: pending climbs to 60 and holds there
        for (int k = 0; k <= 16; k++) begin
            step(3'd4, 0, 1);
            check($sformatf("bp_pending_%0d", k), int'(dut.pending_q), (4 * k > 60) ? 60 : 4 * k);
            check($sformatf("bp_up_%0d", k), last_up, 0);
        end
        check("bp_ready_at_60", int'(bus.credits_ready_o), 0);
        for (int k = 0; k < 15; k++) begin
            step(3'd0, 0, 0);
            check($sformatf("release_up_%0d", k), last_up, 4);
        end
        step(3'd0, 0, 0);
        check("release_done_up", last_up, 0);
        check("release_done_state", int'(dut.state_q), 0);

        // Reset in the middle of a drain with pending=10
        step(3'd4, 0, 1);
        step(3'd4, 0, 1);
        step(3'd2, 0, 1);
        step(3'd0, 0, 1);
        check("mid_pending", int'(dut.pending_q), 10);
        check("mid_state", int'(dut.state_q), 2);
        bus.hold_i = 1'b0;
        #1;
        check("mid_up_before_reset", int'(bus.up_o), 4);
        rst_n = 1'b0;
        #1;
        check("mid_reset_up", int'(bus.up_o), 0);
        check("mid_reset_ready", int'(bus.credits_ready_o), 1);
        check("mid_reset_pending", int'(dut.pending_q), 0);
        sb_q.delete();
        ref_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(3'd0, 0, 0);
            check($sformatf("post_reset_up_%0d", k), last_up, 0);
        end

        // Constrained-random traffic against the reference counter
        for (int k = 0; k < 400; k++) begin
            step(3'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0));
        end
        begin
            int budget;
            budget = 0;
            while (ref_cnt != 0 && budget < 100) begin
                step(3'd0, 0, 0);
                budget++;
            end
            check("quiesce_within_budget", (budget < 100) ? 1 : 0, 1);
        end
        step(3'd0, 0, 0);
        check("final_state_idle", int'(dut.state_q), 0);
        check("final_sb_empty", sb_q.size(), 0);
        check("final_pending", int'(dut.pending_q), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
